fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID register and is its sole producer of `ifid_p` (`instr`, `pc_plus4`).
- Owns the PC and drives the instruction-memory request (`imemREN` / `imemaddr`, completion on `ihit`).
- Absorbs decode-side stalls with a one-entry skid buffer.
- Applies branch/jump redirects and halt from later stages.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory hit; `imemload` valid this cycle.
- imemload  in  32  instruction word returned by memory.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  fetch address (word_t).
- stall  in  1  hazard unit: IF/ID must hold its current contents.
- flush  in  1  redirect taken; squash fetch path.
- redirect_pc  in  32  new PC when flush=1.
- halt  in  1  halt observed downstream; stop fetching.
- ifid_out  out  ifid_p  registered IF/ID payload.
- ifid_valid  out  1  ifid_out holds a real instruction (0 = bubble).

Behaviour:
- Reset (async, nRST=0):
  - pc=PC_INIT; state=FETCH; ifid_out='0; ifid_valid=0; skid empty.
  - imemREN=1 and imemaddr=PC_INIT combinationally as soon as reset releases.
- States: FETCH, HOLD, HALTED (`fetch_state_t`).
- Outputs by state:
  - imemREN=1 only in FETCH.
  - imemaddr=pc in every state.
- Priority each cycle: halt > flush > stall > normal.
- halt=1:
  - Next state HALTED; pc frozen; ifid_out<='0; ifid_valid<=0; skid cleared.
  - HALTED exits only via reset.
- flush=1 (not halted), in any state and regardless of stall:
  - pc<={redirect_pc[31:2],2'b00}; ifid_out<='0; ifid_valid<=0; skid dropped; state<=FETCH.
  - An ihit in the same cycle is discarded.
- FETCH, ihit=1, stall=0:
  - ifid_out<={imemload, pc+4}; ifid_valid<=1; pc<=pc+4.
  - Latency: one edge from ihit to ifid_out.
- FETCH, ihit=1, stall=1:
  - skid<={imemload, pc+4}; pc<=pc+4; state<=HOLD.
  - ifid_out and ifid_valid unchanged.
- FETCH, ihit=0, stall=0: ifid_out<='0; ifid_valid<=0 (bubble); pc unchanged.
- FETCH, ihit=0, stall=1: all registers hold.
- HOLD:
  - imemREN=0; pc holds (already advanced).
  - When stall=0: ifid_out<=skid; ifid_valid<=1; state<=FETCH.
  - The new fetch starts the following cycle.
- Arithmetic: pc+4 is 32-bit modulo and wraps FFFF_FFFC -> 0000_0000 with no flag.
- Stall while ifid_valid=0: the bubble is held; no duplication or loss.
- Correctness: no instruction is delivered twice or lost across any stall/flush sequence.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs `fetch_cnt` [31:0] (ifid_valid rising-transfers, i.e. instructions delivered) and `imiss_cnt` [31:0] (FETCH cycles with imemREN=1 and ihit=0).
  - Both counters clear on reset, saturate at FFFF_FFFF, and freeze in HALTED.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- `fetch_state_t` (FETCH/HOLD/HALTED) goes in pipeline_reg_pkg, next to `ifid_p`.
- PC_INIT default and the `NOP_INSTR` constant (32'h0) go in cpu_types_pkg.
- One sub-module, `fetch_skid_buf`: 1-entry `ifid_p` holding register with load/drain/clear and a full flag. The FSM and PC stay in fetch_stage.

Test Plan:
- Reset, then ihit=1 every cycle, stall=0, imemload=0x2001_0005 -> after edge 1: ifid_out={0x2001_0005, 0x4}, valid=1; after edge 2: imemaddr=0x8.
- ihit=1 with stall=1 at pc=0x10 (imemload=0xAAAA_0000), stall held 3 cycles -> imemREN=0, ifid_out unchanged; on stall release: ifid_out={0xAAAA_0000, 0x14}, then fetch resumes at 0x14.
- flush=1, redirect_pc=0x0000_0102, stall=1, state HOLD -> skid dropped, ifid_valid=0, imemaddr=0x100 next cycle.
- ihit=0 for 4 cycles at pc=0x40 -> ifid_valid=0 throughout, pc stays 0x40; with FETCH_PERF_CNT_EN, imiss_cnt=4.
- halt=1 and flush=1 in the same cycle -> HALTED, imemREN=0, pc frozen, redirect ignored; nRST pulse -> pc=PC_INIT, FETCH.
- PC_INIT=0xFFFF_FFFC, single ihit -> ifid_out.pc_plus4=0x0, next imemaddr=0x0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Basic CPU-wide types and constants shared by every pipeline stage.
//   word_t          : 32-bit machine word
//   PC_INIT_DEFAULT : PC value loaded on reset unless overridden
//   NOP_INSTR       : encoding used for squashed or bubble instructions
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_INIT_DEFAULT = 32'h0000_0000;
    localparam word_t NOP_INSTR       = 32'h0000_0000;

endpackage : cpu_types_pkg

// File: rtl/pipeline_reg_pkg.sv
// pipeline_reg_pkg
// Payload types of the pipeline registers plus the fetch-stage FSM states.
//   ifid_p        : IF/ID payload (fetched instruction and its pc+4)
//   fetch_state_t : FETCH (requesting), HOLD (skid full, waiting on decode),
//                   HALTED (terminal until reset)
package pipeline_reg_pkg;

    import cpu_types_pkg::*;

    typedef struct packed {
        word_t instr;
        word_t pc_plus4;
    } ifid_p;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage : pipeline_reg_pkg

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry holding register for an IF/ID payload that arrived while decode
// was stalled.
// Ports:
//   CLK, nRST : clock, asynchronous active-low reset
//   load      : capture load_data, mark full
//   load_data : payload to capture
//   drain     : entry consumed downstream, mark empty
//   clear     : drop the entry (highest priority)
//   data      : stored payload
//   full      : entry holds a payload
module fetch_skid_buf
    import pipeline_reg_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  ifid_p load_data,
    input  logic  drain,
    input  logic  clear,
    output ifid_p data,
    output logic  full
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: this is a single register rather than a memory array, so it
            // is cheap to reset and the stored payload is never undefined.
            data <= '0;
            full <= 1'b0;
        end else if (clear) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule : fetch_skid_buf

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the PC, issues instruction-memory reads, and
// is the sole producer of the IF/ID register. A decode-side stall that hits
// while a fetch completes parks the instruction in a one-entry skid buffer.
// Priority each cycle: halt > flush > stall > normal.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt / imiss_cnt counters.
// Ports:
//   CLK, nRST   : clock, asynchronous active-low reset
//   ihit        : imemload is valid this cycle
//   imemload    : instruction word from memory
//   imemREN     : read request (FETCH state only)
//   imemaddr    : fetch address (always the PC)
//   stall       : IF/ID must hold its contents
//   flush       : redirect taken, squash fetch path
//   redirect_pc : new PC when flush is set (word aligned internally)
//   halt        : stop fetching until reset
//   ifid_out    : registered IF/ID payload
//   ifid_valid  : ifid_out holds a real instruction
//   fetch_cnt   : instructions delivered (FETCH_PERF_CNT_EN only)
//   imiss_cnt   : FETCH cycles without ihit (FETCH_PERF_CNT_EN only)
module fetch_stage
    import cpu_types_pkg::*;
    import pipeline_reg_pkg::*;
#(
    parameter word_t PC_INIT = PC_INIT_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  word_t       imemload,
    output logic        imemREN,
    output word_t       imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  word_t       redirect_pc,
    input  logic        halt,
    output ifid_p       ifid_out,
    output logic        ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] imiss_cnt
`endif
);

    fetch_state_t state;
    word_t        pc;
    word_t        pc_next_seq;
    ifid_p        fetched;
    ifid_p        skid_data;
    logic         skid_full;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_clear;
    logic         active;
    logic         deliver;

    assign imemREN     = (state == FETCH);
    assign imemaddr    = pc;
    // 32-bit add wraps FFFF_FFFC -> 0000_0000 by construction.
    assign pc_next_seq = pc + 32'd4;
    assign fetched     = '{instr: imemload, pc_plus4: pc_next_seq};

    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        active     = 1'b0;
        skid_clear = 1'b0;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        deliver    = 1'b0;
        if (halt) begin
            skid_clear = 1'b1;
        end else if (state != HALTED) begin
            if (flush) begin
                skid_clear = 1'b1;
            end else begin
                active = 1'b1;
            end
        end
        skid_load  = active && (state == FETCH) && ihit && stall;
        skid_drain = active && (state == HOLD) && !stall;
        deliver    = active && !stall && ((state == HOLD) || ((state == FETCH) && ihit));
    end

    fetch_skid_buf u_skid (
        .CLK       (CLK),
        .nRST      (nRST),
        .load      (skid_load),
        .load_data (fetched),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .data      (skid_data),
        .full      (skid_full)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            ifid_out   <= '0;
            ifid_valid <= 1'b0;
        end else if (halt) begin
            state      <= HALTED;
            ifid_out   <= '0;
            ifid_valid <= 1'b0;
        end else if (state == HALTED) begin
            // Terminal: redirects and stalls are ignored until reset.
            state <= HALTED;
        end else if (flush) begin
            // Any ihit arriving this cycle belongs to the squashed path.
            state      <= FETCH;
            pc         <= {redirect_pc[31:2], 2'b00};
            ifid_out   <= '0;
            ifid_valid <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (ihit && !stall) begin
                        ifid_out   <= fetched;
                        ifid_valid <= 1'b1;
                        pc         <= pc_next_seq;
                    end else if (ihit) begin
                        // Decode is stalled: park the word, advance the PC.
                        pc    <= pc_next_seq;
                        state <= HOLD;
                    end else if (!stall) begin
                        ifid_out   <= '0;
                        ifid_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    // skid_full is always set here; the check keeps the
                    // drain tied to an occupied entry.
                    if (!stall && skid_full) begin
                        ifid_out   <= skid_data;
                        ifid_valid <= 1'b1;
                        state      <= FETCH;
                    end
                end
                default: state <= HALTED;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic imiss;

    // HALTED is never FETCH and never delivers, so both counters freeze there.
    assign imiss = (state == FETCH) && !ihit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt <= '0;
            imiss_cnt <= '0;
        end else begin
            if (deliver && (fetch_cnt != 32'hFFFF_FFFF)) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (imiss && (imiss_cnt != 32'hFFFF_FFFF)) begin
                imiss_cnt <= imiss_cnt + 32'd1;
            end
        end
    end
`else
    // Counters not built; deliver only feeds them, so mark it consumed.
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule : fetch_stage
